// File: rtl/control_estacionamiento_pkg.sv
// Shared constants for the parking-entrance occupancy controller: state codes,
// sensor patterns and default sizing.
package paquete_estacionamiento;

  typedef logic [2:0] estado_t;

  localparam estado_t REPOSO       = 3'd0;
  localparam estado_t ENT_A        = 3'd1;
  localparam estado_t ENT_AB       = 3'd2;
  localparam estado_t ENT_B        = 3'd3;
  localparam estado_t SAL_B        = 3'd4;
  localparam estado_t SAL_BA       = 3'd5;
  localparam estado_t SAL_A        = 3'd6;
  localparam estado_t ESPERA_LIBRE = 3'd7;

  // Sensor patterns are written as {sensor_a, sensor_b}.
  localparam logic [1:0] P_LIBRE = 2'b00;
  localparam logic [1:0] P_A     = 2'b10;
  localparam logic [1:0] P_B     = 2'b01;
  localparam logic [1:0] P_AB    = 2'b11;

  localparam int CAPACIDAD_DEF      = 15;
  localparam int TIMEOUT_CICLOS_DEF = 50_000_000;

  // True while a vehicle is partway through either barrier sequence.
  function automatic logic en_secuencia(input estado_t e);
    return (e != REPOSO) && (e != ESPERA_LIBRE);
  endfunction

endpackage

// File: rtl/control_estacionamiento_temporizador.sv
// Inactivity timer: counts cycles spent in one in-progress state and flags
// when the sequence has been stalled for TIMEOUT_CICLOS cycles.
module temporizador_inactividad #(
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic habilitar,
  input  logic limpiar,
  output logic vencido
);

  localparam int AT = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [AT-1:0] ULTIMO = AT'(TIMEOUT_CICLOS - 1);

  logic [AT-1:0] ciclos;

  always_ff @(posedge clk) begin
    if (!reset || limpiar || !habilitar) begin
      ciclos <= '0;
    end else if (ciclos == ULTIMO) begin
      ciclos <= '0;
    end else begin
      ciclos <= ciclos + AT'(1);
    end
  end

  // Masked by limpiar so a legal transition on the same edge takes priority.
  assign vencido = habilitar && !limpiar && (ciclos == ULTIMO);

endmodule

// File: rtl/control_estacionamiento.sv
// Direction-detecting occupancy controller: decodes A->AB->B->none as an entry
// and B->BA->A->none as an exit, keeping a saturating vehicle count.
module control_estacionamiento
  import paquete_estacionamiento::*;
#(
  parameter int CAPACIDAD      = CAPACIDAD_DEF,
  parameter int ANCHO          = 4,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic [ANCHO-1:0] cuenta,
  output logic             lleno,
  output logic             vacio,
  output logic             pulso_entrada,
  output logic             pulso_salida,
  output logic             error_secuencia
);

  localparam logic [ANCHO-1:0] TOPE = ANCHO'(CAPACIDAD);

  estado_t    estado;
  estado_t    sig_legal;
  estado_t    sig;
  logic [1:0] ab;
  logic       commit_ent;
  logic       commit_sal;
  logic       ilegal;
  logic       vencido;
  logic       limpiar;

  assign ab = {sensor_a, sensor_b};

  // Sensor-driven transitions only; the timeout is layered on afterwards.
  always_comb begin
    sig_legal  = estado;
    commit_ent = 1'b0;
    commit_sal = 1'b0;
    ilegal     = 1'b0;
    case (estado)
      REPOSO: begin
        if (ab == P_A)       sig_legal = ENT_A;
        else if (ab == P_B)  sig_legal = SAL_B;
        else if (ab == P_AB) ilegal    = 1'b1;
      end
      ENT_A: begin
        if (ab == P_AB)         sig_legal = ENT_AB;
        else if (ab == P_LIBRE) sig_legal = REPOSO;
        else if (ab == P_B)     ilegal    = 1'b1;
      end
      ENT_AB: begin
        if (ab == P_B)          sig_legal = ENT_B;
        else if (ab == P_A)     sig_legal = ENT_A;
        else if (ab == P_LIBRE) ilegal    = 1'b1;
      end
      ENT_B: begin
        if (ab == P_LIBRE) begin
          sig_legal  = REPOSO;
          commit_ent = 1'b1;
        end else if (ab == P_AB) sig_legal = ENT_AB;
        else if (ab == P_A)      ilegal    = 1'b1;
      end
      SAL_B: begin
        if (ab == P_AB)         sig_legal = SAL_BA;
        else if (ab == P_LIBRE) sig_legal = REPOSO;
        else if (ab == P_A)     ilegal    = 1'b1;
      end
      SAL_BA: begin
        if (ab == P_A)          sig_legal = SAL_A;
        else if (ab == P_B)     sig_legal = SAL_B;
        else if (ab == P_LIBRE) ilegal    = 1'b1;
      end
      SAL_A: begin
        if (ab == P_LIBRE) begin
          sig_legal  = REPOSO;
          commit_sal = 1'b1;
        end else if (ab == P_AB) sig_legal = SAL_BA;
        else if (ab == P_B)      ilegal    = 1'b1;
      end
      default: begin
        if (ab == P_LIBRE) sig_legal = REPOSO;
      end
    endcase
    if (ilegal) sig_legal = ESPERA_LIBRE;
  end

  assign limpiar = (sig_legal != estado);
  assign sig     = vencido ? ESPERA_LIBRE : sig_legal;

  temporizador_inactividad #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_temporizador (
    .clk       (clk),
    .reset     (reset),
    .habilitar (en_secuencia(estado)),
    .limpiar   (limpiar),
    .vencido   (vencido)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado          <= REPOSO;
      cuenta          <= '0;
      pulso_entrada   <= 1'b0;
      pulso_salida    <= 1'b0;
      error_secuencia <= 1'b0;
    end else begin
      estado          <= sig;
      pulso_entrada   <= 1'b0;
      pulso_salida    <= 1'b0;
      error_secuencia <= ilegal || vencido;
      // A commit that would wrap the count is rejected as an error instead.
      if (commit_ent) begin
        if (cuenta < TOPE) begin
          cuenta        <= cuenta + ANCHO'(1);
          pulso_entrada <= 1'b1;
        end else begin
          error_secuencia <= 1'b1;
        end
      end else if (commit_sal) begin
        if (cuenta != '0) begin
          cuenta       <= cuenta - ANCHO'(1);
          pulso_salida <= 1'b1;
        end else begin
          error_secuencia <= 1'b1;
        end
      end
    end
  end

  assign lleno = (cuenta == TOPE);
  assign vacio = (cuenta == '0);

endmodule

// File: tb/tb_control_estacionamiento.sv
// Bench for control_estacionamiento: directed plan steps plus random sensor
// walks, all checked against a path-position model of the two barriers.
module tb_control_estacionamiento;

  localparam int CAP = 3;
  localparam int TO  = 20;
  localparam int W   = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sensor_a = 1'b1;
  logic         sensor_b = 1'b1;
  logic [W-1:0] cuenta;
  logic         lleno, vacio, pulso_entrada, pulso_salida, error_secuencia;

  int checks = 0;
  int fails  = 0;

  // Reference model state: position along a path, direction, lockout, dwell.
  int m_pos = 0;
  bit m_sal = 0;
  bit m_bloq = 0;
  int m_k = 0;
  int m_cuenta = 0;
  bit e_pe, e_ps, e_err;

  logic [1:0] ruta_ent [1:3];
  logic [1:0] ruta_sal [1:3];
  logic [1:0] anillo [0:3];

  control_estacionamiento #(
    .CAPACIDAD(CAP), .ANCHO(W), .TIMEOUT_CICLOS(TO)
  ) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .cuenta(cuenta), .lleno(lleno), .vacio(vacio),
    .pulso_entrada(pulso_entrada), .pulso_salida(pulso_salida),
    .error_secuencia(error_secuencia)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ruta(input bit sal, input int i);
    if (i < 1 || i > 3) return 2'b00;
    return sal ? ruta_sal[i] : ruta_ent[i];
  endfunction

  function automatic void modelo(input bit rst_n, input logic [1:0] ab);
    logic [1:0] cur, nxt, prv;
    e_pe = 0; e_ps = 0; e_err = 0;
    if (!rst_n) begin
      m_pos = 0; m_bloq = 0; m_k = 0; m_cuenta = 0;
      return;
    end
    if (m_bloq) begin
      if (ab == 2'b00) m_bloq = 0;
      return;
    end
    if (m_pos == 0) begin
      if (ab == 2'b10)      begin m_pos = 1; m_sal = 0; m_k = 1; end
      else if (ab == 2'b01) begin m_pos = 1; m_sal = 1; m_k = 1; end
      else if (ab == 2'b11) begin e_err = 1; m_bloq = 1; end
      return;
    end
    cur = ruta(m_sal, m_pos);
    nxt = ruta(m_sal, m_pos + 1);
    prv = ruta(m_sal, m_pos - 1);
    if (ab == cur) begin
      if (m_k == TO) begin e_err = 1; m_bloq = 1; m_pos = 0; end
      else m_k++;
    end else if (ab == nxt) begin
      if (m_pos == 3) begin
        m_pos = 0;
        if (!m_sal) begin
          if (m_cuenta < CAP) begin m_cuenta++; e_pe = 1; end
          else e_err = 1;
        end else begin
          if (m_cuenta > 0) begin m_cuenta--; e_ps = 1; end
          else e_err = 1;
        end
      end else begin
        m_pos++; m_k = 1;
      end
    end else if (ab == prv) begin
      m_pos--; m_k = 1;
    end else begin
      e_err = 1; m_bloq = 1; m_pos = 0;
    end
  endfunction

  task automatic paso(input bit rst_n, input logic [1:0] ab, input string tag);
    logic [W+4:0] obs, exp_v;
    @(negedge clk);
    reset = rst_n;
    {sensor_a, sensor_b} = ab;
    @(posedge clk);
    modelo(rst_n, ab);
    #1;
    obs   = {cuenta, lleno, vacio, pulso_entrada, pulso_salida, error_secuencia};
    exp_v = {W'(m_cuenta), m_cuenta == CAP, m_cuenta == 0, e_pe, e_ps, e_err};
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed={cuenta,lleno,vacio,pe,ps,err}=%b expected=%b",
             tag, obs, exp_v);
    end
  endtask

  task automatic repetir(input logic [1:0] ab, input int n, input string tag);
    for (int i = 0; i < n; i++) paso(1'b1, ab, tag);
  endtask

  task automatic entrada(input string tag);
    repetir(2'b10, 3, tag); repetir(2'b11, 3, tag);
    repetir(2'b01, 3, tag); repetir(2'b00, 3, tag);
  endtask

  task automatic salida(input string tag);
    repetir(2'b01, 3, tag); repetir(2'b11, 3, tag);
    repetir(2'b10, 3, tag); repetir(2'b00, 3, tag);
  endtask

  initial begin
    logic [1:0] prev;
    int r, idx;
    ruta_ent[1] = 2'b10; ruta_ent[2] = 2'b11; ruta_ent[3] = 2'b01;
    ruta_sal[1] = 2'b01; ruta_sal[2] = 2'b11; ruta_sal[3] = 2'b10;
    anillo[0] = 2'b00; anillo[1] = 2'b10; anillo[2] = 2'b11; anillo[3] = 2'b01;

    paso(1'b0, 2'b11, "reset_hold");
    paso(1'b0, 2'b11, "reset_hold");
    repetir(2'b11, 3, "post_reset_11");
    repetir(2'b10, 2, "locked_until_free");
    repetir(2'b00, 2, "free");

    entrada("entry_1");
    entrada("entry_2");
    salida("exit_from_2");
    entrada("entry_3");
    entrada("entry_4_full");
    entrada("entry_rejected_full");
    for (int i = 0; i < 3; i++) salida("drain");
    salida("exit_rejected_empty");

    repetir(2'b10, 2, "abort_a"); repetir(2'b00, 2, "abort_a");
    repetir(2'b10, 2, "illegal_a_b"); repetir(2'b01, 2, "illegal_a_b");
    repetir(2'b11, 2, "illegal_locked"); repetir(2'b00, 2, "illegal_free");
    repetir(2'b10, 2, "back_out"); repetir(2'b11, 2, "back_out");
    repetir(2'b10, 2, "back_out"); repetir(2'b00, 2, "back_out");

    repetir(2'b10, TO + 3, "timeout_a");
    repetir(2'b00, 2, "timeout_free");

    repetir(2'b10, 2, "reset_mid"); repetir(2'b11, 2, "reset_mid");
    repetir(2'b01, 2, "reset_mid");
    paso(1'b0, 2'b01, "reset_in_ent_b");
    repetir(2'b00, 3, "after_reset_mid");

    prev = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      idx = 0;
      for (int j = 0; j < 4; j++) if (anillo[j] == prev) idx = j;
      if (r < 4)      prev = prev;
      else if (r < 6) prev = anillo[(idx + 1) % 4];
      else if (r < 8) prev = anillo[(idx + 3) % 4];
      else            prev = 2'($urandom_range(0, 3));
      paso($urandom_range(0, 199) != 0, prev, "random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/control_estacionamiento.md
Name: control_estacionamiento

Overview:
- Direction-detecting occupancy controller for a parking entrance with two light barriers, A (outer) and B (inner).
- Consumes the two debounced sensor levels from the sensor front end.
- Decodes the A→AB→B→none order as an entry and B→BA→A→none as an exit, and maintains a saturating occupancy count.
- Flags aborted, illegal or stalled sequences. Feeds the display and barrier logic.

Parameters:
- CAPACIDAD, 15, maximum number of vehicles; the count never exceeds it.
- ANCHO, 4, width of cuenta. Must satisfy 2^ANCHO > CAPACIDAD.
- TIMEOUT_CICLOS, 50_000_000, clk cycles with no input change before a sequence in progress is abandoned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. Sampled only on the clk rising edge; 0 means reset.
- sensor_a  in  1  debounced level of barrier A; 1 means occluded.
- sensor_b  in  1  debounced level of barrier B; 1 means occluded.
- cuenta  out  ANCHO  current occupancy, registered.
- lleno  out  1  high when cuenta == CAPACIDAD.
- vacio  out  1  high when cuenta == 0.
- pulso_entrada  out  1  one-cycle pulse on each counted entry.
- pulso_salida  out  1  one-cycle pulse on each counted exit.
- error_secuencia  out  1  one-cycle pulse on an illegal sequence, a timeout, or a rejected count.

Behaviour:
- **Reset:** reset==0 at a clk edge sets state=REPOSO, cuenta=0, all pulses=0 and timer=0, so lleno=0 and vacio=1. Reset mid-sequence discards the sequence without counting or raising an error.
- **Timing:**
  - Inputs are sampled at each rising edge. State, cuenta and pulses all update at that same edge, so there is zero additional latency beyond the register.
  - lleno and vacio are combinational decodes of the registered cuenta.
- **States:** REPOSO, ENT_A, ENT_AB, ENT_B, SAL_B, SAL_BA, SAL_A, ESPERA_LIBRE. In the transitions below, ab means {sensor_a, sensor_b}.
- **REPOSO:**
  - 10 → ENT_A
  - 01 → SAL_B
  - 11 → error pulse, then ESPERA_LIBRE
  - 00 → stay
- **ENT_A:** 11 → ENT_AB; 00 → REPOSO (abort, no error); 01 → error, ESPERA_LIBRE; 10 → stay.
- **ENT_AB:** 01 → ENT_B; 10 → ENT_A (backing out); 00 → error, ESPERA_LIBRE; 11 → stay.
- **ENT_B:** 00 → commit entry, then REPOSO; 11 → ENT_AB; 10 → error, ESPERA_LIBRE; 01 → stay.
- **Exit states:** SAL_B, SAL_BA and SAL_A mirror the entry states with A and B swapped. Leaving SAL_A on 00 commits an exit.
- **ESPERA_LIBRE:** 00 → REPOSO; any other input → stay. Timeouts are not counted in this state.
- **Commit entry:**
  - If cuenta < CAPACIDAD: cuenta+1 and pulso_entrada=1.
  - Otherwise cuenta is unchanged and error_secuencia=1.
- **Commit exit:**
  - If cuenta > 0: cuenta−1 and pulso_salida=1.
  - Otherwise cuenta is unchanged and error_secuencia=1.
- **Saturation:** the count never wraps in either direction.
- **Timeout:**
  - The timer counts while the state is in {ENT_*, SAL_*}.
  - It clears on any state change and in REPOSO/ESPERA_LIBRE.
  - On reaching TIMEOUT_CICLOS−1: error pulse, state → ESPERA_LIBRE, timer cleared.
  - If a timeout and a legal transition occur on the same edge, the transition wins and the timer clears.
- **Pulse exclusivity:** at most one of pulso_entrada, pulso_salida and error_secuencia is high in any cycle. All three are 0 in every cycle without an event.

Decomposition:
- **Shared package (paquete_estacionamiento):**
  - state enumeration, binary encoding, 3 bits
  - sensor pattern constants P_LIBRE=00, P_A=10, P_B=01, P_AB=11
  - default CAPACIDAD and TIMEOUT_CICLOS
- **Sub-module (temporizador_inactividad):**
  - parameter TIMEOUT_CICLOS
  - inputs clk, reset, habilitar, limpiar
  - output vencido, a one-cycle pulse
- **FSM, counter and pulse registers:** remain in the top module.

Test Plan (bench uses TIMEOUT_CICLOS=20, CAPACIDAD=3):
- Reset: hold reset=0 for 2 cycles with ab=11 → cuenta=0, vacio=1, lleno=0, no pulses. After release, ESPERA_LIBRE until ab=00.
- Full entry: ab 00→10→11→01→00, 3 cycles each → pulso_entrada exactly 1 cycle on the 01→00 edge; cuenta 0→1, vacio=0.
- Full exit after two entries (cuenta=2): ab 01→11→10→00 → pulso_salida 1 cycle; cuenta=1.
- Saturation: four entries from 0 → cuenta=3 with lleno=1; 4th commit gives error_secuencia pulse and cuenta stays 3. With cuenta=0, one exit gives an error pulse and cuenta stays 0.
- Abort and illegal:
  - ab 10→00 → no pulses, cuenta unchanged.
  - ab 10→01 → error pulse, then no count until ab=00.
  - ab 10→11→10→00 → no count.
- Timeout and reset mid-sequence:
  - ab held at 10 for 20 cycles → error pulse on cycle 20, state ESPERA_LIBRE.
  - Separately, reset=0 while in ENT_B → no pulse, cuenta=0.
